// File: rtl/pkt_rr_arbiter_if.sv
// pkt_rr_arbiter_if
// Bundles the source-side and destination-side handshake signals of the
// round-robin packet arbiter.
//   src_valid/src_pkt/src_ready : per-source beat handshake, source i uses
//                                 src_pkt[i*PKT_W +: PKT_W]
//   dst_valid/dst_pkt/dst_ready : shared downstream port
//   grant_id, busy, pkt_count   : status
//   state_dbg                   : raw arbiter FSM state (0 = IDLE, 1 = LOCK)
// Handshake rule for both sides: a beat moves on a rising edge where valid
// and ready are both high; the producer holds valid and data stable until
// that edge, and ready may depend combinationally on the consumer's state.
// Modports: slave = arbiter side, master = environment driving sources and
// the downstream sink.
interface pkt_rr_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int PKT_W   = 13,
  parameter int CNT_W   = 16,
  parameter int GID_W   = $clog2(NUM_SRC)
);
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC*PKT_W-1:0] src_pkt;
  logic [NUM_SRC-1:0]       src_ready;
  logic                     dst_valid;
  logic [PKT_W-1:0]         dst_pkt;
  logic                     dst_ready;
  logic [GID_W-1:0]         grant_id;
  logic                     busy;
  logic [CNT_W-1:0]         pkt_count;
  logic                     state_dbg;

  modport slave (
    input  src_valid, src_pkt, dst_ready,
    output src_ready, dst_valid, dst_pkt, grant_id, busy, pkt_count, state_dbg
  );

  modport master (
    output src_valid, src_pkt, dst_ready,
    input  src_ready, dst_valid, dst_pkt, grant_id, busy, pkt_count, state_dbg
  );
endinterface

// File: rtl/pkt_rr_arbiter.sv
// pkt_rr_arbiter
// Round-robin packet arbiter: locks onto one source for a whole packet
// (ending on the beat with bit 0 = EOP) and forwards its beats through a
// one-entry output register to a single downstream port.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : pkt_rr_arbiter_if.slave (source handshakes, downstream port,
//           grant_id, busy, pkt_count, state_dbg)
module pkt_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int PKT_W   = 13,
  parameter int CNT_W   = 16
) (
  input logic             clk,
  input logic             reset,
  pkt_rr_arbiter_if.slave bus
);
  localparam int GID_W = $clog2(NUM_SRC);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t             state;
  logic [GID_W-1:0]   ptr;
  logic [GID_W-1:0]   grant_id;
  logic               dst_valid;
  logic [PKT_W-1:0]   dst_pkt;
  logic [CNT_W-1:0]   pkt_count;

  logic               sel_any;
  logic [GID_W-1:0]   sel_idx;
  logic [GID_W:0]     scan;
  logic               gnt_valid;
  logic [PKT_W-1:0]   gnt_pkt;
  logic               can_load;
  logic               xfer;
  logic [NUM_SRC-1:0] src_ready;

  // First valid source scanning ptr, ptr+1, ... modulo NUM_SRC. The scan runs
  // from the farthest offset down to offset 0 so the nearest hit wins. scan
  // has one extra bit so ptr+k never overflows before the modulo fold.
  always_comb begin
    sel_any = |bus.src_valid;
    sel_idx = '0;
    scan    = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      scan = {1'b0, ptr} + (GID_W+1)'(k);
      if (scan >= (GID_W+1)'(NUM_SRC))
        scan = scan - (GID_W+1)'(NUM_SRC);
      for (int i = 0; i < NUM_SRC; i++)
        if (bus.src_valid[i] && (scan == (GID_W+1)'(i)))
          sel_idx = GID_W'(i);
    end
  end

  // Beat and valid of the currently granted source.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_pkt   = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (grant_id == GID_W'(i)) begin
        gnt_valid = bus.src_valid[i];
        gnt_pkt   = bus.src_pkt[i*PKT_W +: PKT_W];
      end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign can_load = !dst_valid || bus.dst_ready;
  assign xfer     = (state == LOCK) && gnt_valid && can_load;

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++)
      src_ready[i] = (state == LOCK) && (grant_id == GID_W'(i)) && can_load;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      dst_valid <= 1'b0;
      dst_pkt   <= '0;
      pkt_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            grant_id <= sel_idx;
            state    <= LOCK;
          end
        end
        LOCK: begin
          // A granted source that drops valid mid-packet simply stalls here.
          if (xfer && gnt_pkt[0]) begin
            state <= IDLE;
            ptr   <= (grant_id == GID_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A load wins over a drain, so drain+load keeps dst_valid high.
      if (xfer) begin
        dst_valid <= 1'b1;
        dst_pkt   <= gnt_pkt;
      end else if (dst_valid && bus.dst_ready) begin
        dst_valid <= 1'b0;
      end

      if (dst_valid && bus.dst_ready && dst_pkt[0])
        pkt_count <= pkt_count + 1'b1;
    end
  end

  assign bus.src_ready = src_ready;
  assign bus.dst_valid = dst_valid;
  assign bus.dst_pkt   = dst_pkt;
  assign bus.grant_id  = grant_id;
  assign bus.busy      = (state == LOCK);
  assign bus.pkt_count = pkt_count;
  assign bus.state_dbg = (state == LOCK);
endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// tb_pkt_rr_arbiter
// Bench for pkt_rr_arbiter. Sources are fed from per-source beat queues; a
// reference model turns the queued packets into the expected delivery order
// (round robin over sources that still have packets) and pushes the expected
// beats and grant order into queues popped by the monitor and driver.
// A second, narrow-counter instance exercises pkt_count wrap-around.
module tb_pkt_rr_arbiter;
  localparam int NS = 4;
  localparam int PW = 13;
  localparam int CW = 16;

  logic clk;
  logic rst_n;

  pkt_rr_arbiter_if #(.NUM_SRC(NS), .PKT_W(PW), .CNT_W(CW)) bus ();
  pkt_rr_arbiter #(.NUM_SRC(NS), .PKT_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  pkt_rr_arbiter_if #(.NUM_SRC(2), .PKT_W(PW), .CNT_W(4)) sbus ();
  pkt_rr_arbiter #(.NUM_SRC(2), .PKT_W(PW), .CNT_W(4)) sdut (
    .clk(clk), .reset(rst_n), .bus(sbus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [PW-1:0] src_q[NS][$];
  logic [PW-1:0] mdl_q[NS][$];
  logic [PW-1:0] exp_q[$];
  int          exp_grant_q[$];
  int          model_ptr = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [NS-1:0] mid = '0;
  logic [NS-1:0] acc = '0;
  logic [NS-1:0] force_gap = '0;
  bit          gap_en = 1'b0;
  int          rdy_mode = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
  endtask

  task automatic add_beat(input int i, input logic [PW-1:0] b);
    src_q[i].push_back(b);
    mdl_q[i].push_back(b);
  endtask

  task automatic add_rand_pkt(input int i, input int n);
    logic [PW-1:0] b;
    for (int j = 0; j < n; j++) begin
      b = PW'($urandom);
      b[0] = (j == n - 1);
      add_beat(i, b);
    end
  endtask

  // Reference model: whole packets are served one at a time, each time from
  // the first source at or after model_ptr that still has a packet queued.
  function automatic void schedule();
    int pick;
    int i;
    logic [PW-1:0] b;
    while (1) begin
      pick = -1;
      for (int k = 0; k < NS; k++) begin
        i = (model_ptr + k) % NS;
        if (pick < 0 && mdl_q[i].size() > 0) pick = i;
      end
      if (pick < 0) break;
      exp_grant_q.push_back(pick);
      do begin
        b = mdl_q[pick].pop_front();
        exp_q.push_back(b);
      end while (!b[0] && mdl_q[pick].size() > 0);
      model_ptr = (pick + 1) % NS;
    end
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NS; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic flush();
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
    end
    mid = '0;
    acc = '0;
    exp_q.delete();
    exp_grant_q.delete();
    exp_cnt = '0;
    model_ptr = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      done = (pending() == 0) && (exp_q.size() == 0) && !bus.dst_valid;
    end
    check({name, "_drain"}, done, 1);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_busy"},      bus.busy, 0);
    check({name, "_src_ready"}, bus.src_ready, 0);
    check({name, "_dst_valid"}, bus.dst_valid, 0);
    check({name, "_dst_pkt"},   bus.dst_pkt, 0);
    check({name, "_pkt_count"}, bus.pkt_count, 0);
    check({name, "_grant_id"},  bus.grant_id, 0);
    check({name, "_state"},     bus.state_dbg, 0);
  endtask

  // ---------------- source / sink driver ----------------
  initial begin
    logic [PW-1:0]    b;
    logic [NS-1:0]    v;
    logic [NS*PW-1:0] p;
    int               e;
    bus.src_valid = '0;
    bus.src_pkt   = '0;
    bus.dst_ready = 1'b0;
    forever begin
      @(negedge clk);
      acc = bus.src_valid & bus.src_ready;
      for (int i = 0; i < NS; i++)
        if (acc[i] && !mid[i]) begin
          e = -1;
          if (exp_grant_q.size() > 0) e = exp_grant_q.pop_front();
          check("grant_order", i, e);
          check("grant_id", bus.grant_id, i);
        end
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++)
        if (acc[i] && src_q[i].size() > 0) begin
          b = src_q[i].pop_front();
          mid[i] = !b[0];
        end
      v = '0;
      p = '0;
      for (int i = 0; i < NS; i++) begin
        b = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        v[i] = (src_q[i].size() > 0) &&
               !(mid[i] && (force_gap[i] || (gap_en && $urandom_range(0, 3) == 0)));
        p[i*PW +: PW] = b;
      end
      bus.src_valid = v;
      bus.src_pkt   = p;
      case (rdy_mode)
        0:       bus.dst_ready = ($urandom_range(0, 3) != 0);
        1:       bus.dst_ready = 1'b1;
        default: bus.dst_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic          prev_stall;
    logic [PW-1:0] prev_pkt;
    logic [PW-1:0] e;
    prev_stall = 1'b0;
    prev_pkt   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        check("pkt_count", bus.pkt_count, exp_cnt);
        check("ready_onehot", ($countones(bus.src_ready) <= 1), 1);
        if (prev_stall) begin
          check("hold_valid", bus.dst_valid, 1);
          check("hold_pkt", bus.dst_pkt, prev_pkt);
        end
        if (bus.dst_valid && bus.dst_ready) begin
          check("beat_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dst_pkt", bus.dst_pkt, e);
            if (e[0]) exp_cnt = exp_cnt + 1'b1;
          end
        end
        prev_stall = bus.dst_valid && !bus.dst_ready;
        prev_pkt   = bus.dst_pkt;
      end
    end
  end

  // ---------------- narrow-counter instance ----------------
  task automatic send_small(input int n);
    int got = 0;
    @(posedge clk);
    #1;
    sbus.src_valid = 2'b01;
    sbus.dst_ready = 1'b1;
    for (int k = 0; k < 200 && got < n; k++) begin
      @(negedge clk);
      if (sbus.src_valid[0] && sbus.src_ready[0]) got++;
    end
    @(posedge clk);
    #1;
    sbus.src_valid = 2'b00;
    check("small_sent", got, n);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    sbus.src_valid = '0;
    sbus.src_pkt   = {13'h0000, 13'h0155};
    sbus.dst_ready = 1'b0;

    #12;
    check_reset_vals("por");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Fairness: every source holds two single-beat packets.
    @(negedge clk);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NS; i++) add_rand_pkt(i, 1);
    schedule();
    wait_drain("fair", 200);

    // Single source, single beat: latency and counter.
    @(negedge clk);
    add_beat(0, 13'h1A03);
    schedule();
    @(negedge clk);
    check("single_c0_busy", bus.busy, 0);
    check("single_c0_dst_valid", bus.dst_valid, 0);
    @(negedge clk);
    check("single_c1_busy", bus.busy, 1);
    check("single_c1_src_ready", bus.src_ready, 4'b0001);
    @(negedge clk);
    check("single_c2_dst_valid", bus.dst_valid, 1);
    check("single_c2_dst_pkt", bus.dst_pkt, 13'h1A03);
    check("single_c2_busy", bus.busy, 0);
    @(negedge clk);
    check("single_count", bus.pkt_count, 9);

    // Packet lock: src1 three beats while src0 and src2 also request.
    @(negedge clk);
    add_rand_pkt(0, 1);
    add_beat(1, 13'h0802);
    add_beat(1, 13'h0804);
    add_beat(1, 13'h0807);
    add_rand_pkt(2, 1);
    schedule();
    wait_drain("lock", 200);

    // Backpressure: output register full, sink stalled for 5 cycles.
    @(negedge clk);
    rdy_mode = 2;
    add_rand_pkt(0, 3);
    schedule();
    for (int k = 0; k < 50 && !bus.dst_valid; k++) @(negedge clk);
    check("bp_loaded", bus.dst_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_src_ready", bus.src_ready, 0);
      check("bp_dst_valid", bus.dst_valid, 1);
    end
    rdy_mode = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_resume_valid", bus.dst_valid, 1);
    end
    wait_drain("bp", 200);

    // Stall: src1 drops valid mid-packet for 3 cycles.
    @(negedge clk);
    force_gap = 4'b0010;
    add_rand_pkt(1, 3);
    add_rand_pkt(0, 1);
    add_rand_pkt(3, 1);
    schedule();
    for (int k = 0; k < 100 && !mid[1]; k++) @(negedge clk);
    check("stall_reached", mid[1], 1);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      check("stall_busy", bus.busy, 1);
      check("stall_grant", bus.grant_id, 1);
      check("stall_src_valid", bus.src_valid[1], 0);
      check("stall_others", (bus.src_ready & 4'b1101), 0);
    end
    force_gap = '0;
    wait_drain("stall", 200);

    // Randomised batches with random gaps and sink backpressure.
    gap_en = 1'b1;
    rdy_mode = 0;
    for (int bt = 0; bt < 6; bt++) begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        int n = $urandom_range(0, 3);
        for (int p = 0; p < n; p++) add_rand_pkt(i, $urandom_range(1, 4));
      end
      schedule();
      wait_drain("rand", 1500);
    end
    gap_en = 1'b0;

    // Asynchronous reset with a beat waiting in the output register.
    @(negedge clk);
    rdy_mode = 2;
    add_rand_pkt(3, 3);
    schedule();
    for (int k = 0; k < 50 && !bus.dst_valid; k++) @(negedge clk);
    check("rst_pre_valid", bus.dst_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    flush();
    @(negedge clk);
    #2 rst_n = 1'b1;
    rdy_mode = 1;
    @(negedge clk);
    add_rand_pkt(2, 1);
    schedule();
    for (int k = 0; k < 20 && !bus.busy; k++) @(negedge clk);
    check("rst_first_busy", bus.busy, 1);
    check("rst_first_grant", bus.grant_id, 2);
    wait_drain("post_rst", 100);

    // Counter wrap on a 4-bit pkt_count instance.
    @(negedge clk);
    check("small_cnt_start", sbus.pkt_count, 0);
    send_small(15);
    check("small_cnt_max", sbus.pkt_count, 4'hF);
    send_small(1);
    check("small_cnt_wrap", sbus.pkt_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pkt_rr_arbiter.md
# pkt_rr_arbiter

Round-robin packet arbiter that shares the single packet datapath (packet generator / router input) among `NUM_SRC` requesting sources. Sources present 13-bit packet beats with a valid/ready handshake. The arbiter locks onto one source for a whole packet, which ends on the beat with the EOP bit set, and forwards its beats through a one-entry registered output stage to the shared downstream port. It sits between the source-side packet producers and the packet generation/routing block.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesting sources (2..8).
- `PKT_W`, 13: beat width. Field layout: `[12:11]` dst_addr, `[10:9]` pack_t, `[8:1]` payload, `[0]` eop.
- `CNT_W`, 16: width of the completed-packet counter.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `src_valid`  in  NUM_SRC  per-source beat valid.
- `src_pkt`  in  NUM_SRC*PKT_W  per-source beat; source i occupies bits `[i*PKT_W +: PKT_W]`.
- `src_ready`  out  NUM_SRC  per-source beat accept; at most one bit is high.
- `dst_valid`  out  1  output register holds a beat.
- `dst_pkt`  out  PKT_W  output beat.
- `dst_ready`  in  1  downstream accepts `dst_pkt` this cycle.
- `grant_id`  out  $clog2(NUM_SRC)  currently/last granted source.
- `busy`  out  1  high while in LOCK.
- `pkt_count`  out  CNT_W  number of EOP beats delivered downstream (dst_valid & dst_ready & dst_pkt[0]).

## Operation
- FSM has two states, IDLE and LOCK. A round-robin pointer `ptr` gives the highest-priority source index.
- IDLE: if any `src_valid` is high, select the first valid source scanning `ptr, ptr+1, …` modulo NUM_SRC. On the next edge, `grant_id` = that source and state = LOCK. Otherwise stay in IDLE. All `src_ready` are 0 in IDLE.
- LOCK: `src_ready[grant_id] = !dst_valid || dst_ready`. All other `src_ready` bits are 0.
- A beat transfers when `src_valid[grant_id] & src_ready[grant_id]`. On the next edge it is loaded into the output register.
- If the accepted beat has `pkt[0]`=1 (EOP): next state is IDLE and `ptr` = `grant_id`+1, wrapping to 0 at NUM_SRC.
- If the granted source drops `src_valid` mid-packet, the arbiter stays in LOCK and waits. No timeout.
- Output register:
  - Load on source transfer.
  - Clear `dst_valid` on `dst_valid & dst_ready` with no simultaneous load.
  - A simultaneous drain and load keeps `dst_valid`=1 with the new beat.
  - Drains normally in IDLE as well.
- While `dst_valid`=1 and `dst_ready`=0, `dst_pkt` and `dst_valid` are held stable.
- Beats are forwarded unmodified. No reordering and no drops.
- `pkt_count` increments by 1 per delivered EOP beat and wraps modulo 2^CNT_W.
- Sources must hold `src_pkt` and `src_valid` stable until accepted. Behaviour is undefined otherwise.

## Timing
- Reset (`reset`=0, asynchronous):
  - state = IDLE, `ptr` = 0, `grant_id` = 0.
  - `busy` = 0, `src_ready` = 0, `dst_valid` = 0, `dst_pkt` = 0, `pkt_count` = 0.
  - Any in-flight beat or packet is discarded.
- Reset release is sampled synchronously. The first arbitration occurs on the first edge with `reset`=1.
- Arbitration takes 1 cycle: `src_valid` seen in IDLE at edge N gives `busy`=1 and `src_ready` available in cycle N+1.
- Minimum latency is 2 cycles from `src_valid` rising in IDLE to `dst_valid`. Accept to `dst_valid` is 1 cycle.
- Within a packet, with `dst_ready` held high, throughput is 1 beat/cycle.
- Between packets there is exactly 1 idle arbitration cycle: `src_ready` is 0 for all sources in the cycle after an EOP transfer.
- A single-beat packet (eop=1 on the first beat) occupies LOCK for 1 cycle when `dst_ready`=1.
- `grant_id` holds its last value in IDLE.

## Test plan
- **Reset:** assert `reset`=0 mid-simulation with `dst_valid`=1 → all outputs return to reset values immediately, without waiting for a clock edge. After release, the first request from src2 is granted with `grant_id`=2.
- **Single source:** src0 sends 13'h1A03 (eop=1) with `dst_ready`=1 → `dst_valid` 2 cycles after `src_valid`, `dst_pkt`=13'h1A03, `pkt_count`=1, `busy` back to 0.
- **Fairness:** all 4 sources hold single-beat EOP packets continuously → grant order 0,1,2,3,0,1; each source gets exactly one packet per 4 grants.
- **Packet lock:** src1 sends 3 beats 13'h0802, 13'h0804, 13'h0807 while src0 and src2 request throughout → all 3 src1 beats delivered contiguously, then src2 is granted (ptr=2), not src0.
- **Backpressure:** `dst_ready`=0 for 5 cycles with `dst_valid`=1 → `dst_pkt` stable and `src_ready`=0. On release, beats resume with no loss or duplication, and the simultaneous drain/load cycle keeps `dst_valid`=1.
- **Stall and wrap:** the granted source drops valid for 3 cycles mid-packet → `busy` stays 1 and no other source is granted. Separately, preset `pkt_count` to 16'hFFFF via 65535 packets or force, deliver one EOP → `pkt_count` = 0.
